// File: rtl/halfadder_bhv.sv
// Purpose: WIDTH-bit adder with combinational and registered sum/carry plus a saturating carry-event counter.
// Latency: S/Cout are 0-cycle combinational; S_q/Cout_q/carry_cnt update one clk edge after sampling.
// Backpressure: none; the block accepts new operands on every cycle and has no handshake.
module halfadder_bhv #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Carry is the extra MSB of a WIDTH+1 bit add; reset never touches this path.
    always_comb begin
        sum_full = {1'b0, A} + {1'b0, B};
    end

    assign S    = sum_full[WIDTH-1:0];
    assign Cout = sum_full[WIDTH];

    always_comb begin
        sum_d  = S;
        cout_d = Cout;
        cnt_d  = cnt_q;
        if (Cout && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign S_q       = sum_q;
    assign Cout_q    = cout_q;
    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_halfadder_bhv.sv
// Directed bench for halfadder_bhv: 1-bit/16-bit counter, 1-bit/2-bit counter and 4-bit instances.
module tb_halfadder_bhv;

    logic clk;
    logic rst_n;

    logic       a0, b0, s0, c0, sq0, cq0;
    logic [15:0] cnt0;
    logic       a1, b1, s1, c1, sq1, cq1;
    logic [1:0] cnt1;
    logic [3:0] a4, b4, s4, sq4;
    logic       c4, cq4;
    logic [15:0] cnt4;

    int tests;
    int fails;

    halfadder_bhv #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .S(s0), .Cout(c0),
        .S_q(sq0), .Cout_q(cq0), .carry_cnt(cnt0)
    );

    halfadder_bhv #(.WIDTH(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .S(s1), .Cout(c1),
        .S_q(sq1), .Cout_q(cq1), .carry_cnt(cnt1)
    );

    halfadder_bhv #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .S(s4), .Cout(c4),
        .S_q(sq4), .Cout_q(cq4), .carry_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        a0 = 1'b1; b0 = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset state, and combinational path still live under reset.
        chk("rst_sq0", sq0, 0);
        chk("rst_cq0", cq0, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_sq4", sq4, 0);
        chk("rst_s0", s0, 0);
        chk("rst_c0", c0, 1);
        tick();
        chk("rst_hold_cnt0", cnt0, 0);
        chk("rst_hold_cq0", cq0, 0);
        a0 = 1'b0; b0 = 1'b0;
        rst_n = 1'b1;

        // Truth table: combinational now, registered after one edge.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            logic exp_s, exp_c;
            v = i[1:0];
            a0 = v[1]; b0 = v[0];
            exp_s = v[1] ^ v[0];
            exp_c = v[1] & v[0];
            #1;
            chk($sformatf("tt_s_%0d", i), s0, exp_s);
            chk($sformatf("tt_c_%0d", i), c0, exp_c);
            tick();
            chk($sformatf("tt_sq_%0d", i), sq0, exp_s);
            chk($sformatf("tt_cq_%0d", i), cq0, exp_c);
        end
        chk("tt_cnt0", cnt0, 1);

        // Mid-cycle reset pulse clears everything without an edge.
        rst_n = 1'b0;
        #1;
        chk("pulse_cnt0", cnt0, 0);
        chk("pulse_cq0", cq0, 0);
        rst_n = 1'b1;

        a0 = 1'b1; b0 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("cnt_up_%0d", k), cnt0, k);
        end
        a0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("cnt_hold_%0d", k), cnt0, 5);
        end
        chk("pre_rst_sq0", sq0, 1);

        // Reset between edges with count at 5.
        a0 = 1'b1; b0 = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sq0", sq0, 0);
        chk("mid_rst_cq0", cq0, 0);
        chk("mid_rst_cnt0", cnt0, 0);
        chk("mid_rst_s0", s0, 0);
        chk("mid_rst_c0", c0, 1);
        a0 = 1'b0;
        #1;
        chk("mid_rst_s0b", s0, 1);
        chk("mid_rst_c0b", c0, 0);
        tick();
        chk("in_rst_cnt0", cnt0, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_sq0", sq0, 1);
        chk("post_rst_cq0", cq0, 0);
        chk("post_rst_cnt0", cnt0, 0);

        // Saturation of a 2-bit counter.
        a1 = 1'b1; b1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            int e;
            e = (k > 3) ? 3 : k;
            tick();
            chk($sformatf("sat_%0d", k), cnt1, e);
        end
        a1 = 1'b0;
        tick();
        chk("sat_hold", cnt1, 3);

        // 4-bit operands.
        a4 = 4'hF; b4 = 4'h1;
        #1;
        chk("w4_s_f1", s4, 4'h0);
        chk("w4_c_f1", c4, 1);
        tick();
        chk("w4_sq_f1", sq4, 4'h0);
        chk("w4_cq_f1", cq4, 1);
        chk("w4_cnt", cnt4, 1);
        a4 = 4'h7; b4 = 4'h8;
        #1;
        chk("w4_s_78", s4, 4'hF);
        chk("w4_c_78", c4, 0);
        a4 = 4'h9; b4 = 4'h9;
        #1;
        chk("w4_s_99", s4, 4'h2);
        chk("w4_c_99", c4, 1);

        // Several input changes between edges: only the last one is captured.
        a4 = 4'h3; b4 = 4'h4;
        #2;
        chk("w4_sq_hold", sq4, 4'h0);
        a4 = 4'h5; b4 = 4'h6;
        tick();
        chk("w4_sq_56", sq4, 4'hB);
        chk("w4_cq_56", cq4, 0);
        chk("w4_cnt_56", cnt4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
